// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - multi-channel counted/continuous pulse train generator with shared prescaler
module pulse_train_gen #(
   parameter int N_CH       = 4,
   parameter int CNT_W      = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PRESCALE_W-1:0]   prescale_div,
   input  logic [N_CH-1:0]         start,
   input  logic [N_CH-1:0]         abort,
   input  logic [N_CH-1:0]         repeat_en,
   input  logic [N_CH*CNT_W-1:0]   num_pulses,
   output logic [N_CH-1:0]         pulse_out,
   output logic [N_CH-1:0]         busy,
   output logic [N_CH-1:0]         done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_HIGH  = 2'd2,
      S_LOW   = 2'd3
   } ch_state_t;

   logic [PRESCALE_W-1:0] pre_cnt;
   logic                  tick;

   // >= rather than == so a lowered divide takes effect without waiting for a wrap
   assign tick = (pre_cnt >= prescale_div);

   // Shared prescaler: free-running counter that restarts after every tick
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRESCALE_W'(1);
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ch_state_t        state, state_nxt;
      logic [CNT_W-1:0] rem, rem_nxt;
      logic [CNT_W-1:0] lat_cnt, lat_cnt_nxt;
      logic             lat_rep, lat_rep_nxt;
      logic             done_q, done_nxt;
      logic             ch_pulse, ch_busy;
      logic [CNT_W-1:0] num;

      assign num = num_pulses[g*CNT_W +: CNT_W];

      // Channel state and datapath registers
      always_ff @(posedge clk) begin
         if (rst) begin
            state   <= S_IDLE;
            rem     <= '0;
            lat_cnt <= '0;
            lat_rep <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            lat_cnt <= lat_cnt_nxt;
            lat_rep <= lat_rep_nxt;
            done_q  <= done_nxt;
         end
      end

      // Next-state: abort dominates, otherwise advance only on the shared tick
      always_comb begin
         state_nxt   = state;
         rem_nxt     = rem;
         lat_cnt_nxt = lat_cnt;
         lat_rep_nxt = lat_rep;
         done_nxt    = 1'b0;
         if (state == S_IDLE) begin
            if (start[g] && !abort[g] && (num != '0)) begin
               state_nxt   = S_ARMED;
               rem_nxt     = num;
               lat_cnt_nxt = num;
               lat_rep_nxt = repeat_en[g];
            end
         end else if (abort[g]) begin
            state_nxt = S_IDLE;
         end else if (tick) begin
            case (state)
               S_ARMED: state_nxt = S_HIGH;
               S_HIGH: begin
                  state_nxt = S_LOW;
                  rem_nxt   = rem - CNT_W'(1);
               end
               S_LOW: begin
                  if (rem != '0) begin
                     state_nxt = S_HIGH;
                  end else if (lat_rep) begin
                     state_nxt = S_HIGH;
                     rem_nxt   = lat_cnt;
                  end else begin
                     state_nxt = S_IDLE;
                     done_nxt  = 1'b1;
                  end
               end
               default: state_nxt = S_IDLE;
            endcase
         end
      end

      // Outputs decoded from the registered state
      always_comb begin
         ch_pulse = (state == S_HIGH);
         ch_busy  = (state != S_IDLE);
      end

      assign pulse_out[g] = ch_pulse;
      assign busy[g]      = ch_busy;
      assign done[g]      = done_q;
   end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter N_CH, default 4: number of independent pulse channels (1..16).
REQ-002 Parameter CNT_W, default 4: width of per-channel pulse-count field.
REQ-003 Parameter PRESCALE_W, default 8: width of shared prescaler divide field.
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 prescale_div  input  PRESCALE_W  tick period minus one, in clk cycles; 0 = tick every cycle.
REQ-007 start  input  N_CH  per-channel start request, sampled every cycle.
REQ-008 abort  input  N_CH  per-channel abort request, sampled every cycle.
REQ-009 repeat  input  N_CH  per-channel continuous-mode select, sampled with start.
REQ-010 num_pulses  input  N_CH*CNT_W  per-channel pulse count; channel i uses bits [i*CNT_W +: CNT_W].
REQ-011 pulse_out  output  N_CH  registered pulse train per channel.
REQ-012 busy  output  N_CH  high while channel not IDLE.
REQ-013 done  output  N_CH  one-cycle completion strobe per channel.

Function
REQ-014 Shared prescaler counter SHALL increment each cycle; when counter >= prescale_div, tick SHALL be high that cycle and the counter SHALL return to 0 next cycle.
REQ-015 A prescale_div change SHALL take effect immediately via the >= compare; no channel state SHALL be disturbed.
REQ-016 Each channel SHALL have states IDLE, ARMED, HIGH, LOW and a CNT_W-bit remaining counter rem, plus latched count and latched repeat.
REQ-017 IDLE: start=1, abort=0, num_pulses!=0 -> ARMED next cycle; rem, latched count <= num_pulses; latched repeat <= repeat.
REQ-018 IDLE: start with num_pulses==0 SHALL be ignored (no busy, no done).
REQ-019 ARMED on tick -> HIGH; HIGH on tick -> LOW with rem <= rem-1.
REQ-020 LOW on tick: rem!=0 -> HIGH; rem==0 and latched repeat=1 -> HIGH with rem <= latched count; rem==0 and latched repeat=0 -> IDLE with done=1 for exactly the next cycle.
REQ-021 Without tick, every state SHALL hold.
REQ-022 pulse_out[i] SHALL equal (state==HIGH); each pulse high and low for exactly prescale_div+1 cycles when prescale_div is static.
REQ-023 busy[i] SHALL equal (state!=IDLE).
REQ-024 start while busy SHALL be ignored; num_pulses/repeat changes while busy SHALL NOT affect the running train.
REQ-025 abort=1 in any non-IDLE state -> IDLE next cycle, pulse_out=0, done NOT asserted.
REQ-026 abort and start both high in IDLE: abort wins, start ignored.
REQ-027 Channels SHALL be fully independent apart from the shared tick.
REQ-028 Continuous mode SHALL run until abort or rst; done never asserted in it.

Reset
REQ-029 rst=1 SHALL force, on the next edge, all channels IDLE, rem and latched fields 0, prescaler counter 0, pulse_out=0, busy=0, done=0.
REQ-030 rst SHALL override start and abort in the same cycle, including mid-pulse.

Verification
REQ-031 N_CH=4, div=0, ch0 num=3 repeat=0, start 1 cycle at edge 0 -> pulse_out[0] high after edges 1,3,5; busy[0] high 7 cycles; done[0] high only after edge 7.
REQ-032 div=3, ch1 num=2 -> each pulse high 4 cycles, low 4 cycles, exactly 2 pulses, then single done[1].
REQ-033 ch2 num=1 repeat=1, div=0 -> pulse_out[2] toggles every cycle indefinitely, no done; abort[2] mid-HIGH -> pulse_out[2]=0, busy[2]=0 next cycle, no done.
REQ-034 ch0 and ch3 started same cycle with num=5 and num=2 -> independent correct counts; second start on ch0 while busy ignored; start with num=0 -> no busy.
REQ-035 rst asserted during HIGH on all channels -> all outputs 0 next cycle; subsequent start runs full correct count.
REQ-036 abort+start same cycle in IDLE -> channel stays IDLE, busy=0.
